cpu_trace_monitor: RTL and testbench
====================================

// Module: cpu_trace_monitor
// PURPOSE
//  Synthesizable run-control and trace-capture block that sits beside the MIPS core.
//  It starts a run, tags every executed cycle, and buffers {PC, Instruction, ALUResult, Zero}
//  samples in a parametrised FIFO that a host drains through a valid/ready port.
//  It ends the run on a halt instruction, a PC stall, or a cycle budget (timeout).
// PARAMETERS
//  ADDR_W       32            PC width
//  DATA_W       32            ALUResult width
//  DEPTH        16            trace FIFO entries; power of two, >=2
//  CNT_W        16            cycle counter / tag width
//  MAX_CYCLES   25            cycle budget per run; 1 <= MAX_CYCLES < 2**CNT_W
//  HALT_INSTR   32'h0000000C  instruction encoding that ends a run (syscall)
//  STALL_LIMIT  3             consecutive repeated-PC samples that end a run; >=1
//  OVERWRITE    0             1: full FIFO evicts oldest; 0: new sample is dropped
// PORTS
//  clk          in   1             clock, rising edge
//  reset        in   1             asynchronous, active-high
//  start        in   1             begin a run (sampled in IDLE/HALTED/TIMEOUT)
//  pc           in   ADDR_W        core PC
//  instr        in   32            core Instruction
//  alu_result   in   DATA_W        core ALUResult
//  zero         in   1             core Zero
//  rd_ready     in   1             host accepts head entry
//  rd_valid     out  1             FIFO non-empty
//  rd_pc        out  ADDR_W        head sample PC
//  rd_instr     out  32            head sample instruction
//  rd_alu       out  DATA_W        head sample ALUResult
//  rd_zero      out  1             head sample Zero
//  rd_cycle     out  CNT_W         head sample cycle tag
//  count        out  $clog2(DEPTH)+1  entries held
//  state        out  2             0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT
//  cycle_count  out  CNT_W         cycles captured in the current run
//  halted, timeout, overflow  out  1  status flags
// BEHAVIOUR
//  - Reset (async): state=IDLE, FIFO empty, all outputs 0, stall counter 0, prev-PC invalid.
//  - IDLE/HALTED/TIMEOUT + start=1: next edge -> RUN. Clears cycle_count, halted, timeout,
//    stall counter and prev-PC valid. FIFO contents and overflow are kept. start is ignored in RUN.
//  - RUN: every edge pushes {pc,instr,alu_result,zero,cycle_count}, then cycle_count+1.
//  - Stall detection: if pc==prev_pc and prev-PC is valid, the stall counter increments;
//    otherwise it resets to 0. prev_pc updates on every RUN edge.
//  - End of run: the sample that triggers the end is still captured. Next state:
//      instr==HALT_INSTR or stall counter reaching STALL_LIMIT -> HALTED, halted=1;
//      otherwise, if the captured tag == MAX_CYCLES-1 -> TIMEOUT, timeout=1.
//    Halt has priority over timeout when both occur on the same edge.
//  - HALTED/TIMEOUT: no capture; the FIFO keeps draining.
//  - FIFO: circular, pointer wrap modulo DEPTH.
//    - rd_* show the head entry. A pop happens when rd_valid && rd_ready.
//    - Write-to-read latency is 1 cycle: a sample pushed on edge t is visible from t+1. No bypass.
//    - Full + push, no pop:
//        OVERWRITE=1: head advances (oldest lost), count stays DEPTH, overflow=1;
//        OVERWRITE=0: the sample is dropped, cycle_count still increments, overflow=1.
//    - Full + push + pop on the same edge: both occur, count stays DEPTH, no overflow.
//    - Empty + pop: impossible (rd_valid=0).
//    - rd_* hold stable while rd_valid && !rd_ready, except for an OVERWRITE=1 eviction.
//  - overflow is sticky until reset. cycle_count never exceeds MAX_CYCLES.
// TESTING
//  T1 DEPTH=32, start, 30 cycles of non-halt instrs with distinct PCs -> 25 entries, tags 0..24,
//     state=TIMEOUT, timeout=1, halted=0.
//  T2 instr=32'h0000000C at tag 5 -> 6 entries (last has instr 0000000C), state=HALTED,
//     cycle_count=6.
//  T3 STALL_LIMIT=3, pc=0x10 for tags 0..3 -> halted after tag 3, 4 entries.
//  T4 DEPTH=4, rd_ready=0, halt at tag 5:
//     OVERWRITE=0 -> count=4, overflow=1, drain tags 0,1,2,3;
//     OVERWRITE=1 -> drain tags 2,3,4,5.
//  T5 full FIFO, rd_ready=1 during RUN -> no overflow, tags read strictly in order with no gaps.
//  T6 reset pulse mid-run with 3 entries -> outputs 0 before the next edge, state=IDLE,
//     rd_valid=0; a new start restarts tags at 0.

Source files
------------

// File: rtl/cpu_trace_monitor.sv
// Run-control and trace capture beside the MIPS core: tags every executed cycle and
// queues {pc, instr, alu_result, zero, tag} samples for a host draining via valid/ready.
module cpu_trace_monitor #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 16,
    parameter int          CNT_W       = 16,
    parameter int          MAX_CYCLES  = 25,
    parameter logic [31:0] HALT_INSTR  = 32'h0000_000C,
    parameter int          STALL_LIMIT = 3,
    parameter bit          OVERWRITE   = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        pc,
    input  logic [31:0]              instr,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic                     zero,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [ADDR_W-1:0]        rd_pc,
    output logic [31:0]              rd_instr,
    output logic [DATA_W-1:0]        rd_alu,
    output logic                     rd_zero,
    output logic [CNT_W-1:0]         rd_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state,
    output logic [CNT_W-1:0]         cycle_count,
    output logic                     halted,
    output logic                     timeout,
    output logic                     overflow
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int OCC_W     = PTR_W + 1;
    localparam int STALL_W   = $clog2(STALL_LIMIT + 1);
    localparam int ENTRY_W   = ADDR_W + 32 + DATA_W + 1 + CNT_W;
    localparam int ZERO_BIT  = CNT_W;
    localparam int ALU_LSB   = CNT_W + 1;
    localparam int INSTR_LSB = ALU_LSB + DATA_W;
    localparam int PC_LSB    = INSTR_LSB + 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cycle_reg, cycle_next;
    logic                halted_reg, halted_next;
    logic                timeout_reg, timeout_next;
    logic                overflow_reg;
    logic [STALL_W-1:0]  stall_reg, stall_next;
    logic [ADDR_W-1:0]   prev_pc_reg, prev_pc_next;
    logic                prev_valid_reg, prev_valid_next;
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [OCC_W-1:0]    count_reg, count_next;

    logic                capture;
    logic                stall_match;
    logic                stall_hit;
    logic                last_tag;
    logic                full;
    logic                pop;
    logic                wr_en;
    logic                evict;
    logic                rd_adv;
    logic                overflow_set;
    logic [ENTRY_W-1:0]  wr_data;
    logic [ENTRY_W-1:0]  head;
    logic [ENTRY_W-1:0]  head_masked;

    logic [ENTRY_W-1:0]  mem [DEPTH];

    assign stall_match = prev_valid_reg && (pc == prev_pc_reg);
    // The limit is reached on the edge whose incremented count equals STALL_LIMIT.
    assign stall_hit   = stall_match && (stall_reg == STALL_W'(STALL_LIMIT - 1));
    assign last_tag    = (cycle_reg == CNT_W'(MAX_CYCLES - 1));

    always_comb begin
        state_next      = state_reg;
        cycle_next      = cycle_reg;
        halted_next     = halted_reg;
        timeout_next    = timeout_reg;
        stall_next      = stall_reg;
        prev_pc_next    = prev_pc_reg;
        prev_valid_next = prev_valid_reg;
        capture         = 1'b0;
        case (state_reg)
            ST_RUN: begin
                capture         = 1'b1;
                cycle_next      = cycle_reg + CNT_W'(1);
                prev_pc_next    = pc;
                prev_valid_next = 1'b1;
                stall_next      = stall_match ? (stall_reg + STALL_W'(1)) : '0;
                if ((instr == HALT_INSTR) || stall_hit) begin
                    state_next  = ST_HALTED;
                    halted_next = 1'b1;
                end else if (last_tag) begin
                    state_next   = ST_TIMEOUT;
                    timeout_next = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_next      = ST_RUN;
                    cycle_next      = '0;
                    halted_next     = 1'b0;
                    timeout_next    = 1'b0;
                    stall_next      = '0;
                    prev_valid_next = 1'b0;
                end
            end
        endcase
    end

    // A full FIFO only accepts a sample if a slot frees this edge or eviction is allowed.
    assign full         = (count_reg == OCC_W'(DEPTH));
    assign pop          = rd_valid && rd_ready;
    assign wr_en        = capture && (!full || pop || OVERWRITE);
    assign evict        = capture && full && !pop && OVERWRITE;
    assign rd_adv       = pop || evict;
    assign overflow_set = capture && full && !pop;
    assign wr_data      = {pc, instr, alu_result, zero, cycle_reg};

    always_comb begin
        count_next = count_reg;
        if (wr_en && !rd_adv) begin
            count_next = count_reg + OCC_W'(1);
        end else if (!wr_en && rd_adv) begin
            count_next = count_reg - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cycle_reg      <= '0;
            halted_reg     <= 1'b0;
            timeout_reg    <= 1'b0;
            overflow_reg   <= 1'b0;
            stall_reg      <= '0;
            prev_pc_reg    <= '0;
            prev_valid_reg <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            cycle_reg      <= cycle_next;
            halted_reg     <= halted_next;
            timeout_reg    <= timeout_next;
            overflow_reg   <= overflow_reg | overflow_set;
            stall_reg      <= stall_next;
            prev_pc_reg    <= prev_pc_next;
            prev_valid_reg <= prev_valid_next;
            count_reg      <= count_next;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_adv) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    assign head     = mem[rd_ptr_reg];
    assign rd_valid = (count_reg != '0);

    // Empty FIFO presents all-zero data so outputs are defined straight out of reset.
    generate
        for (genvar gi = 0; gi < ENTRY_W; gi++) begin : g_head_mask
            assign head_masked[gi] = head[gi] & rd_valid;
        end
    endgenerate

    assign rd_cycle    = head_masked[CNT_W-1:0];
    assign rd_zero     = head_masked[ZERO_BIT];
    assign rd_alu      = head_masked[ALU_LSB +: DATA_W];
    assign rd_instr    = head_masked[INSTR_LSB +: 32];
    assign rd_pc       = head_masked[PC_LSB +: ADDR_W];

    assign count       = count_reg;
    assign state       = state_reg;
    assign cycle_count = cycle_reg;
    assign halted      = halted_reg;
    assign timeout     = timeout_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Bench for cpu_trace_monitor: three configurations share one stimulus stream and are
// compared each cycle against a queue-based model, plus hand-computed literal checks.
module tb_cpu_trace_monitor;

    localparam logic [31:0] HALT = 32'h0000_000C;
    localparam int NI    = 3;
    localparam int MAXC  = 25;
    localparam int SLIM  = 3;
    localparam int S_IDLE = 0, S_RUN = 1, S_HALTED = 2, S_TIMEOUT = 3;

    logic        clk = 1'b0;
    logic        reset, start, zero, rd_ready;
    logic [31:0] pc, instr, alu_result;

    logic        o_rd_valid    [NI];
    logic [31:0] o_rd_pc       [NI];
    logic [31:0] o_rd_instr    [NI];
    logic [31:0] o_rd_alu      [NI];
    logic        o_rd_zero     [NI];
    logic [15:0] o_rd_cycle    [NI];
    logic [1:0]  o_state       [NI];
    logic [15:0] o_cycle_count [NI];
    logic        o_halted      [NI];
    logic        o_timeout     [NI];
    logic        o_overflow    [NI];
    logic [5:0]  o_count       [NI];
    logic [5:0]  cnt_a;
    logic [2:0]  cnt_b, cnt_c;

    assign o_count[0] = cnt_a;
    assign o_count[1] = {3'b000, cnt_b};
    assign o_count[2] = {3'b000, cnt_c};

    always #5 clk = ~clk;

    cpu_trace_monitor #(.DEPTH(32), .OVERWRITE(1'b0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr),
        .alu_result(alu_result), .zero(zero), .rd_ready(rd_ready),
        .rd_valid(o_rd_valid[0]), .rd_pc(o_rd_pc[0]), .rd_instr(o_rd_instr[0]),
        .rd_alu(o_rd_alu[0]), .rd_zero(o_rd_zero[0]), .rd_cycle(o_rd_cycle[0]),
        .count(cnt_a), .state(o_state[0]), .cycle_count(o_cycle_count[0]),
        .halted(o_halted[0]), .timeout(o_timeout[0]), .overflow(o_overflow[0]));

    cpu_trace_monitor #(.DEPTH(4), .OVERWRITE(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr),
        .alu_result(alu_result), .zero(zero), .rd_ready(rd_ready),
        .rd_valid(o_rd_valid[1]), .rd_pc(o_rd_pc[1]), .rd_instr(o_rd_instr[1]),
        .rd_alu(o_rd_alu[1]), .rd_zero(o_rd_zero[1]), .rd_cycle(o_rd_cycle[1]),
        .count(cnt_b), .state(o_state[1]), .cycle_count(o_cycle_count[1]),
        .halted(o_halted[1]), .timeout(o_timeout[1]), .overflow(o_overflow[1]));

    cpu_trace_monitor #(.DEPTH(4), .OVERWRITE(1'b1)) dut_c (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr),
        .alu_result(alu_result), .zero(zero), .rd_ready(rd_ready),
        .rd_valid(o_rd_valid[2]), .rd_pc(o_rd_pc[2]), .rd_instr(o_rd_instr[2]),
        .rd_alu(o_rd_alu[2]), .rd_zero(o_rd_zero[2]), .rd_cycle(o_rd_cycle[2]),
        .count(cnt_c), .state(o_state[2]), .cycle_count(o_cycle_count[2]),
        .halted(o_halted[2]), .timeout(o_timeout[2]), .overflow(o_overflow[2]));

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic        zero;
        logic [15:0] tag;
    } entry_t;

    // Model: index 0 of mq is always the oldest sample.
    entry_t      mq    [NI][32];
    int          mn    [NI];
    int          mst   [NI];
    int          mcyc  [NI];
    int          mstl  [NI];
    bit          mhalt [NI];
    bit          mto   [NI];
    bit          movf  [NI];
    bit          mpv   [NI];
    logic [31:0] mppc  [NI];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int depth_of(input int k);
        return (k == 0) ? 32 : 4;
    endfunction

    function automatic bit ovw_of(input int k);
        return (k == 2);
    endfunction

    task automatic check(input string name, input int k, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, k, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            mn[k] = 0; mst[k] = S_IDLE; mcyc[k] = 0; mstl[k] = 0;
            mhalt[k] = 0; mto[k] = 0; movf[k] = 0; mpv[k] = 0; mppc[k] = '0;
        end
    endtask

    task automatic drop_oldest(input int k);
        for (int i = 0; i < mn[k] - 1; i++) mq[k][i] = mq[k][i+1];
        mn[k]--;
    endtask

    task automatic model_step();
        entry_t e;
        bit end_halt, end_to;
        for (int k = 0; k < NI; k++) begin
            if (mn[k] > 0 && rd_ready) drop_oldest(k);
            if (mst[k] == S_RUN) begin
                e.pc = pc; e.instr = instr; e.alu = alu_result; e.zero = zero;
                e.tag = 16'(mcyc[k]);
                if (mpv[k] && pc == mppc[k]) mstl[k]++; else mstl[k] = 0;
                mppc[k] = pc;
                mpv[k]  = 1'b1;
                end_halt = (instr == HALT) || (mstl[k] >= SLIM);
                end_to   = (mcyc[k] == MAXC - 1);
                if (mn[k] < depth_of(k)) begin
                    mq[k][mn[k]] = e;
                    mn[k]++;
                end else begin
                    movf[k] = 1'b1;
                    if (ovw_of(k)) begin
                        drop_oldest(k);
                        mq[k][mn[k]] = e;
                        mn[k]++;
                    end
                end
                mcyc[k]++;
                if (end_halt) begin
                    mst[k] = S_HALTED; mhalt[k] = 1'b1;
                end else if (end_to) begin
                    mst[k] = S_TIMEOUT; mto[k] = 1'b1;
                end
            end else if (start) begin
                mst[k] = S_RUN; mcyc[k] = 0; mhalt[k] = 0; mto[k] = 0;
                mstl[k] = 0; mpv[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            check("state", k, 64'(o_state[k]), 64'(mst[k]));
            check("count", k, 64'(o_count[k]), 64'(mn[k]));
            check("cycle_count", k, 64'(o_cycle_count[k]), 64'(mcyc[k]));
            check("halted", k, 64'(o_halted[k]), 64'(mhalt[k]));
            check("timeout", k, 64'(o_timeout[k]), 64'(mto[k]));
            check("overflow", k, 64'(o_overflow[k]), 64'(movf[k]));
            check("rd_valid", k, 64'(o_rd_valid[k]), 64'(mn[k] > 0));
            if (mn[k] > 0) begin
                check("rd_pc", k, 64'(o_rd_pc[k]), 64'(mq[k][0].pc));
                check("rd_instr", k, 64'(o_rd_instr[k]), 64'(mq[k][0].instr));
                check("rd_alu", k, 64'(o_rd_alu[k]), 64'(mq[k][0].alu));
                check("rd_zero", k, 64'(o_rd_zero[k]), 64'(mq[k][0].zero));
                check("rd_cycle", k, 64'(o_rd_cycle[k]), 64'(mq[k][0].tag));
            end
        end
    endtask

    task automatic step();
        if (rd_ready && o_rd_valid[0])
            $display("[TB] pop tag=%0d pc=0x%08h instr=0x%08h", o_rd_cycle[0],
                     o_rd_pc[0], o_rd_instr[0]);
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive_sample(input int i, input int halt_at, input bit fixed_pc);
        pc         = fixed_pc ? 32'h0000_0010 : 32'h0000_1000 + 32'(i * 4);
        instr      = (i == halt_at) ? HALT : 32'h2008_0000 + 32'(i);
        alu_result = 32'hA5A5_0000 ^ 32'(i * 7);
        zero       = (i % 3 == 0);
    endtask

    task automatic run_cycles(input int n, input int halt_at, input bit fixed_pc);
        for (int i = 0; i < n; i++) begin
            drive_sample(i, halt_at, fixed_pc);
            step();
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
        rd_ready = 1'b0;
    endtask

    // Pulse reset between edges; every output must drop before the next clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        for (int k = 0; k < NI; k++) begin
            check("rst_state", k, 64'(o_state[k]), 64'd0);
            check("rst_rd_valid", k, 64'(o_rd_valid[k]), 64'd0);
            check("rst_count", k, 64'(o_count[k]), 64'd0);
            check("rst_rd_pc", k, 64'(o_rd_pc[k]), 64'd0);
            check("rst_rd_cycle", k, 64'(o_rd_cycle[k]), 64'd0);
            check("rst_cycle_count", k, 64'(o_cycle_count[k]), 64'd0);
        end
        #1 reset = 1'b0;
    endtask

    int nexttag;

    initial begin
        reset = 1'b1; start = 1'b0; rd_ready = 1'b0;
        pc = '0; instr = '0; alu_result = '0; zero = 1'b0;
        model_reset();
        #3;
        check_all();
        check("t0_state", 0, 64'(o_state[0]), 64'd0);
        check("t0_rd_valid", 0, 64'(o_rd_valid[0]), 64'd0);
        check("t0_overflow", 0, 64'(o_overflow[0]), 64'd0);
        #10 reset = 1'b0;

        // T2/T4: halt at tag 5 with the host stalled
        do_start();
        run_cycles(8, 5, 1'b0);
        check("t2_count", 0, 64'(o_count[0]), 64'd6);
        check("t2_state", 0, 64'(o_state[0]), 64'd2);
        check("t2_cycle_count", 0, 64'(o_cycle_count[0]), 64'd6);
        check("t2_halted", 0, 64'(o_halted[0]), 64'd1);
        check("t4_count", 1, 64'(o_count[1]), 64'd4);
        check("t4_overflow", 1, 64'(o_overflow[1]), 64'd1);
        check("t4_count", 2, 64'(o_count[2]), 64'd4);
        check("t4_overflow", 2, 64'(o_overflow[2]), 64'd1);
        check("t4_overflow", 0, 64'(o_overflow[0]), 64'd0);
        rd_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            check("t2_tag", 0, 64'(o_rd_cycle[0]), 64'(j));
            if (j == 5) check("t2_last_instr", 0, 64'(o_rd_instr[0]), 64'h0000_000C);
            if (j < 4) begin
                check("t4_drop_tag", 1, 64'(o_rd_cycle[1]), 64'(j));
                check("t4_evict_tag", 2, 64'(o_rd_cycle[2]), 64'(j + 2));
            end
            step();
        end
        rd_ready = 1'b0;

        // T3: repeated PC ends the run after tag 3
        do_start();
        run_cycles(6, -1, 1'b1);
        check("t3_count", 0, 64'(o_count[0]), 64'd4);
        check("t3_state", 0, 64'(o_state[0]), 64'd2);
        check("t3_cycle_count", 0, 64'(o_cycle_count[0]), 64'd4);
        drain(6);

        // T1: cycle budget expires
        do_start();
        run_cycles(30, -1, 1'b0);
        check("t1_count", 0, 64'(o_count[0]), 64'd25);
        check("t1_state", 0, 64'(o_state[0]), 64'd3);
        check("t1_timeout", 0, 64'(o_timeout[0]), 64'd1);
        check("t1_halted", 0, 64'(o_halted[0]), 64'd0);
        check("t1_cycle_count", 0, 64'(o_cycle_count[0]), 64'd25);
        rd_ready = 1'b1;
        for (int j = 0; j < 25; j++) begin
            check("t1_tag", 0, 64'(o_rd_cycle[0]), 64'(j));
            step();
        end
        drain(3);

        // T5: full FIFO drained concurrently with capture
        do_reset();
        do_start();
        nexttag = 0;
        for (int i = 0; i < 34; i++) begin
            rd_ready = (i >= 4);
            drive_sample(i, -1, 1'b0);
            if (rd_ready && o_rd_valid[1]) begin
                check("t5_order", 1, 64'(o_rd_cycle[1]), 64'(nexttag));
                nexttag++;
            end
            step();
        end
        rd_ready = 1'b0;
        check("t5_pops", 1, 64'(nexttag), 64'd25);
        check("t5_overflow", 1, 64'(o_overflow[1]), 64'd0);
        check("t5_overflow", 2, 64'(o_overflow[2]), 64'd0);

        // T6: reset mid-run with three entries held, then a fresh run
        do_start();
        run_cycles(3, -1, 1'b0);
        check("t6_count", 0, 64'(o_count[0]), 64'd3);
        do_reset();
        do_start();
        run_cycles(2, -1, 1'b0);
        check("t6_restart_tag", 0, 64'(o_rd_cycle[0]), 64'd0);
        check("t6_cycle_count", 0, 64'(o_cycle_count[0]), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
